// File: rtl/skolem_chk_pkg.sv
// Shared types and helpers for the Skolem-function self-checkers.
// spec_ok() holds the relation under test; other checkers swap this function.
package skolem_chk_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  // Wide enough for TIMEOUT up to 255.
  localparam int TO_W  = 8;
  localparam int MAX_W = 16;

  // XOR specification: parity of the universals equals parity of the Skolem outputs.
  function automatic logic spec_ok(input logic [MAX_W-1:0] x, input logic [MAX_W-1:0] y);
    return (^x) == (^y);
  endfunction

endpackage

// File: rtl/skolem_xor_checker.sv
// Exhaustive sweep of all 2^NUM_X universal assignments against a candidate
// Skolem function; reports pass, y_valid timeout, or the first counterexample.
module skolem_xor_checker
  import skolem_chk_pkg::*;
#(
  parameter int NUM_X   = 5,
  parameter int NUM_Y   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [NUM_X-1:0] x_vec,
  output logic             x_valid,
  input  logic [NUM_Y-1:0] y_vec,
  input  logic             y_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [NUM_X-1:0] cex_x,
  output logic [NUM_Y-1:0] cex_y,
  output logic [NUM_X:0]   vec_count
);

  state_e            state, state_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic [NUM_Y-1:0]  y_reg;
  logic [MAX_W-1:0]  x_ext, y_ext;
  logic              vec_ok, last_vec, to_expire;

  always_comb begin
    x_ext = '0;
    y_ext = '0;
    x_ext[NUM_X-1:0] = x_vec;
    y_ext[NUM_Y-1:0] = y_reg;
  end

  assign vec_ok    = spec_ok(x_ext, y_ext);
  assign last_vec  = &x_vec;
  assign to_expire = (to_cnt <= TO_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_DRIVE;
      S_DRIVE:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (y_valid)        state_nxt = S_CHECK;
        else if (to_expire) state_nxt = S_FINISH;
      end
      S_CHECK:  state_nxt = (!vec_ok || last_vec) ? S_FINISH : S_DRIVE;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    x_valid = (state == S_DRIVE) || (state == S_WAIT);
    busy    = (state != S_IDLE);
    done    = (state == S_FINISH);
  end

  // Sweep datapath; results land on the edge entering FINISH so they line up with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_vec     <= '0;
      y_reg     <= '0;
      to_cnt    <= '0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      cex_x     <= '0;
      cex_y     <= '0;
      vec_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            x_vec     <= '0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            cex_x     <= '0;
            cex_y     <= '0;
            vec_count <= '0;
          end
        end
        S_DRIVE: to_cnt <= TO_W'(TIMEOUT);
        S_WAIT: begin
          if (y_valid) begin
            y_reg <= y_vec;
          end else if (to_expire) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            to_cnt <= to_cnt - TO_W'(1);
          end
        end
        S_CHECK: begin
          if (!vec_ok) begin
            cex_x <= x_vec;
            cex_y <= y_reg;
            pass  <= 1'b0;
          end else begin
            vec_count <= vec_count + 1'b1;
            if (last_vec) pass  <= 1'b1;
            else          x_vec <= x_vec + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_xor_checker.sv
// Scoreboarded bench: a reference sweep model pushes the expected outcome at
// each start, popped and compared when done pulses.
module tb_skolem_xor_checker;

  localparam int NX = 5;
  localparam int NY = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NX-1:0] x_vec;
  logic          x_valid;
  logic [NY-1:0] y_vec;
  logic          y_valid;
  logic          busy, done, pass, timeout;
  logic [NX-1:0] cex_x;
  logic [NY-1:0] cex_y;
  logic [NX:0]   vec_count;

  int checks = 0;
  int failures = 0;
  int mode = 0;  // 0 correct, 1 y=0, 2 bug at 10110, 3 no y_valid, 4 delayed y_valid

  typedef struct {
    logic          pass;
    logic          to;
    logic [NX-1:0] cx;
    logic [NY-1:0] cy;
    logic [NX:0]   vc;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  skolem_xor_checker #(.NUM_X(NX), .NUM_Y(NY), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_vec(x_vec), .x_valid(x_valid), .y_vec(y_vec), .y_valid(y_valid),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .cex_x(cex_x), .cex_y(cex_y), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  function automatic logic [NY-1:0] cand(input int m, input logic [NX-1:0] x);
    logic [NY-1:0] y;
    y = {1'b0, ^x};
    if (m == 1) y = '0;
    if (m == 2 && x == 5'b10110) y = {1'b0, ~(^x)};
    return y;
  endfunction

  // Candidate under test
  int xv_cnt = 0;
  always @(posedge clk) xv_cnt <= x_valid ? xv_cnt + 1 : 0;
  always_comb begin
    y_vec   = cand(mode, x_vec);
    y_valid = (mode == 3) ? 1'b0 : (mode == 4) ? (x_valid && xv_cnt >= 3) : 1'b1;
  end

  // Protocol monitors: x_vec stability under x_valid, vector order, done pulses
  logic          prev_v = 1'b0;
  logic [NX-1:0] prev_x = '0;
  logic [NX-1:0] exp_next = '0;
  int stab_err = 0, order_err = 0, done_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      prev_v   <= 1'b0;
      exp_next <= '0;
    end else begin
      prev_v <= x_valid;
      prev_x <= x_vec;
      if (x_valid && prev_v && x_vec !== prev_x) stab_err <= stab_err + 1;
      if (start && !busy) exp_next <= '0;
      else if (x_valid && !prev_v) begin
        if (x_vec !== exp_next) order_err <= order_err + 1;
        exp_next <= x_vec + 1'b1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  function automatic exp_t model(input int m);
    exp_t e;
    int per;
    logic [NX-1:0] xv;
    logic [NY-1:0] y;
    e.pass = 1'b0; e.to = 1'b0; e.cx = '0; e.cy = '0; e.vc = '0; e.cyc = 0;
    per = (m == 4) ? 5 : 3;
    if (m == 3) begin
      e.to  = 1'b1;
      e.cyc = 17;
      return e;
    end
    for (int x = 0; x < 32; x++) begin
      xv = x[NX-1:0];
      y  = cand(m, xv);
      if ((^xv) != (^y)) begin
        e.cx  = xv;
        e.cy  = y;
        e.vc  = x[NX:0];
        e.cyc = per * (x + 1) + 1;
        return e;
      end
    end
    e.pass = 1'b1;
    e.vc   = 6'd32;
    e.cyc  = per * 32 + 1;
    return e;
  endfunction

  task automatic run_sweep(input int m, input string name, input bit inj);
    exp_t e;
    int cyc;
    bit got;
    mode = m;
    sb.push_back(model(m));
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL %s busy_after_start got=%b exp=1", name, busy);
    end
    cyc = 1; got = (done === 1'b1);
    while (!got && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
      start = inj && (cyc == 5);
      if (done === 1'b1) got = 1;
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!got) begin
      failures++; $display("FAIL %s done_timeout got=none exp=cycle %0d", name, e.cyc);
      return;
    end
    if (cyc != e.cyc) begin
      failures++; $display("FAIL %s cycles got=%0d exp=%0d", name, cyc, e.cyc);
    end
    checks++;
    if (pass !== e.pass) begin
      failures++; $display("FAIL %s pass got=%b exp=%b", name, pass, e.pass);
    end
    checks++;
    if (timeout !== e.to) begin
      failures++; $display("FAIL %s timeout got=%b exp=%b", name, timeout, e.to);
    end
    checks++;
    if (cex_x !== e.cx || cex_y !== e.cy) begin
      failures++; $display("FAIL %s cex got=%b/%b exp=%b/%b", name, cex_x, cex_y, e.cx, e.cy);
    end
    checks++;
    if (vec_count !== e.vc) begin
      failures++; $display("FAIL %s vec_count got=%0d exp=%0d", name, vec_count, e.vc);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s after_done got done=%b busy=%b exp=0/0", name, done, busy);
    end
    checks++;
    if (pass !== e.pass || vec_count !== e.vc) begin
      failures++; $display("FAIL %s held got pass=%b vc=%0d exp=%b/%0d", name, pass, vec_count, e.pass, e.vc);
    end
    checks++;
    if (stab_err != 0 || order_err != 0) begin
      failures++; $display("FAIL %s protocol got stab=%0d order=%0d exp=0/0", name, stab_err, order_err);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({x_vec, x_valid, busy, done, pass, timeout, cex_x, cex_y, vec_count} !== '0) begin
      failures++;
      $display("FAIL %s reset_vals got x=%b xv=%b busy=%b done=%b pass=%b to=%b cx=%b cy=%b vc=%0d exp=all0",
               name, x_vec, x_valid, busy, done, pass, timeout, cex_x, cex_y, vec_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 check_reset_vals("reset_idle");
  endtask

  task automatic test_pass();        run_sweep(0, "pass",    1'b0); endtask
  task automatic test_force_zero();  run_sweep(1, "y_zero",  1'b0); endtask
  task automatic test_single_bug();  run_sweep(2, "bug22",   1'b0); endtask
  task automatic test_timeout();     run_sweep(3, "timeout", 1'b0); endtask
  task automatic test_delayed();     run_sweep(4, "delayed", 1'b0); endtask

  task automatic test_back_to_back();
    run_sweep(1, "b2b_fail", 1'b1);
    run_sweep(0, "b2b_pass", 1'b1);
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    int dc;
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (!(x_valid === 1'b1 && x_vec === 5'd10) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 500) begin
      failures++; $display("FAIL mid_rst reach_vec10 got=none exp=x_vec 10");
    end
    dc = done_cnt;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 check_reset_vals("mid_rst");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done_cnt != dc || done !== 1'b0) begin
      failures++; $display("FAIL mid_rst done_pulse got=%0d exp=%0d", done_cnt, dc);
    end
    run_sweep(0, "after_rst", 1'b0);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_force_zero();
    test_single_bug();
    test_timeout();
    test_delayed();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
